// File: rtl/ex_mdu_if.sv
// Execute-stage link between the pipeline (master) and the iterative MDU (slave):
// issue request, flush, stall feedback and the register-file write triple.
interface ex_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd_addr_in;
    logic            flush;
    logic            busy;
    logic            stall_req;
    logic            valid;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            rd_wen;

    modport master (
        output start, op, op1, op2, rd_addr_in, flush,
        input  busy, stall_req, valid, rd_addr, rd_data, rd_wen
    );

    modport slave (
        input  start, op, op1, op2, rd_addr_in, flush,
        output busy, stall_req, valid, rd_addr, rd_data, rd_wen
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative unsigned multiply/divide unit: fixed XLEN-cycle shift-add multiply or
// restoring divide, holding the pipeline while it runs and writing back for one cycle.
module ex_mdu #(
    parameter int unsigned XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    ex_mdu_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    localparam logic [1:0] OpMul   = 2'd0;
    localparam logic [1:0] OpMulhu = 2'd1;
    localparam logic [1:0] OpDivu  = 2'd2;
    localparam logic [1:0] OpRemu  = 2'd3;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_rem;
    logic [4:0]      r_rd_addr;
    logic            r_div0;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_rem_sub;
    logic            w_q_bit;
    logic            w_accept;
    logic            w_last;
    logic            w_valid;
    logic [XLEN-1:0] w_result;

    // Multiply: r_acc is the high half, r_op2 shifts out multiplier bits and
    // collects the low half. Divide: r_op1 shifts out dividend bits and collects quotient.
    assign w_sum     = {1'b0, r_acc} + (r_op2[0] ? {1'b0, r_op1} : '0);
    assign w_rem_sh  = {r_rem, r_op1[XLEN-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_op2};
    assign w_q_bit   = ~w_rem_sub[XLEN];

    assign w_accept = (r_state == StIdle) && bus.start && !bus.flush;
    assign w_last   = (r_cnt == CntW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_op      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_rd_addr <= '0;
            r_div0    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op      <= bus.op;
                        r_op1     <= bus.op1;
                        r_op2     <= bus.op2;
                        r_rd_addr <= bus.rd_addr_in;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_rem     <= '0;
                        r_div0    <= bus.op[1] && (bus.op2 == '0);
                        r_state   <= (bus.op[1] && (bus.op2 == '0)) ? StDone : StCalc;
                    end
                end
                StCalc: begin
                    if (bus.flush) begin
                        r_state <= StIdle;
                    end else begin
                        if (r_op[1]) begin
                            r_rem <= w_q_bit ? w_rem_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                            r_op1 <= {r_op1[XLEN-2:0], w_q_bit};
                        end else begin
                            {r_acc, r_op2} <= {w_sum, r_op2[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        w_result = '0;
        unique case (r_op)
            OpMul:   w_result = r_op2;
            OpMulhu: w_result = r_acc;
            OpDivu:  w_result = r_div0 ? '1 : r_op1;
            OpRemu:  w_result = r_div0 ? r_op1 : r_rem;
        endcase
    end

    // Flush kills the write-back in the same cycle it is raised.
    assign w_valid       = (r_state == StDone) && !bus.flush;
    assign bus.valid     = w_valid;
    assign bus.rd_wen    = w_valid;
    assign bus.rd_addr   = w_valid ? r_rd_addr : '0;
    assign bus.rd_data   = w_valid ? w_result : '0;
    assign bus.busy      = (r_state != StIdle);
    assign bus.stall_req = w_accept || (r_state == StCalc);
endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: scoreboard of expected write-backs (data, address and
// arrival cycle) checked by a monitor, plus per-scenario stall/abort checks.
module tb_ex_mdu;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mdu_if #(.XLEN(XLEN)) bus ();

    ex_mdu #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (op)
            2'd0:    return p[XLEN-1:0];
            2'd1:    return p[2*XLEN-1:XLEN];
            2'd2:    return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bus.valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: cycle %0d addr %0d data %h, required no write",
                             cyc, bus.rd_addr, bus.rd_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.rd_wen !== 1'b1 || bus.rd_addr !== mon_e.addr ||
                        bus.rd_data !== mon_e.data || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL result: got wen %b addr %0d data %h cycle %0d, required wen 1 addr %0d data %h cycle %0d",
                                 bus.rd_wen, bus.rd_addr, bus.rd_data, cyc,
                                 mon_e.addr, mon_e.data, mon_e.cyc);
                    end
                end
            end else if (bus.valid !== 1'b0 || bus.rd_wen !== 1'b0 ||
                         bus.rd_addr !== 5'd0 || bus.rd_data !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs: cycle %0d valid %b wen %b addr %0d data %h, required all 0",
                         cyc, bus.valid, bus.rd_wen, bus.rd_addr, bus.rd_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] addr, output int k);
        exp_t e;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.op1 = a; bus.op2 = b; bus.rd_addr_in = addr;
        k = cyc;
        e.addr = addr;
        e.data = model(op, a, b);
        e.cyc  = k + ((op[1] && b == '0) ? 1 : XLEN + 1);
        sb.push_back(e);
        @(negedge clk);
        n_checks++;
        if (bus.stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_stall: cycle %0d stall_req %b, required 1", cyc, bus.stall_req);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0 && sb.size() == 0) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_idle: busy %b pending %0d after 200 cycles, required idle and none",
                     bus.busy, sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({bus.busy, bus.stall_req, bus.valid, bus.rd_wen} !== 4'b0 ||
            bus.rd_addr !== 5'd0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL %s: busy %b stall %b valid %b wen %b addr %0d data %h, required all 0",
                     name, bus.busy, bus.stall_req, bus.valid, bus.rd_wen, bus.rd_addr,
                     bus.rd_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0;
        bus.op1 = '0; bus.op2 = '0; bus.rd_addr_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_outputs");
        mon_en = 1'b1;
    endtask

    task automatic test_mul();
        int k;
        issue(2'd0, 32'd7, 32'd6, 5'd5, k);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.stall_req !== 1'b1) begin
                n_fail++;
                $display("FAIL mul_stall_calc: cycle k+%0d stall_req %b, required 1", i, bus.stall_req);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.stall_req !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_done_stall: stall_req %b busy %b, required 0 and 1",
                     bus.stall_req, bus.busy);
        end
        wait_idle();
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, k);
        wait_idle();
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, k);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            issue(2'(i % 2), $urandom, $urandom, 5'(i + 11), k);
            wait_idle();
        end
    endtask

    task automatic test_div();
        int k;
        issue(2'd2, 32'd100, 32'd7, 5'd1, k);         wait_idle();
        issue(2'd3, 32'd100, 32'd7, 5'd2, k);         wait_idle();
        issue(2'd2, 32'h8000_0000, 32'd1, 5'd3, k);   wait_idle();
        issue(2'd3, 32'h8000_0000, 32'd1, 5'd4, k);   wait_idle();
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, k); wait_idle();
        for (int i = 0; i < 4; i++) begin
            issue(2'(2 + i % 2), $urandom, $urandom_range(32'hFFFF, 1), 5'(i + 20), k);
            wait_idle();
        end
    endtask

    task automatic test_div_zero();
        int k;
        for (int i = 0; i < 2; i++) begin
            issue(2'(2 + i), 32'h1234, 32'd0, 5'(10 + i), k);
            @(negedge clk);
            n_checks++;
            if (bus.stall_req !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL divzero_stall: op %0d stall_req %b busy %b, required 0 and 1",
                         2 + i, bus.stall_req, bus.busy);
            end
            wait_idle();
        end
    endtask

    task automatic test_flush();
        int k;
        issue(2'd2, 32'd100, 32'd7, 5'd4, k);
        sb.delete(sb.size() - 1);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        check_all_zero("flush_calc_idle");
        repeat (40) @(posedge clk);
        issue(2'd0, 32'd3, 32'd5, 5'd6, k);
        sb.delete(sb.size() - 1);
        repeat (32) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.valid !== 1'b0 || bus.rd_wen !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: valid %b wen %b busy %b, required 0 0 1",
                     bus.valid, bus.rd_wen, bus.busy);
        end
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        check_all_zero("flush_done_idle");
        wait_idle();
    endtask

    task automatic test_rst_abort();
        int k;
        issue(2'd2, 32'd100, 32'd7, 5'd4, k);
        sb.delete(sb.size() - 1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_abort");
        repeat (40) @(posedge clk);
    endtask

    task automatic test_ignored_start();
        int k;
        issue(2'd2, 32'd100, 32'd7, 5'd3, k);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'd0; bus.op1 = 32'd3; bus.op2 = 32'd3; bus.rd_addr_in = 5'd9;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();
        repeat (40) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int   k;
        exp_t e;
        issue(2'd0, 32'd11, 32'd13, 5'd1, k);
        bus.start = 1'b1; bus.op = 2'd3; bus.op1 = 32'd1000; bus.op2 = 32'd33; bus.rd_addr_in = 5'd2;
        e.addr = 5'd2;
        e.data = model(2'd3, 32'd1000, 32'd33);
        e.cyc  = k + 34 + XLEN + 1;
        sb.push_back(e);
        repeat (32) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_stall: stall_req %b in DONE with start high, required 0",
                     bus.stall_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept_stall: stall_req %b in IDLE with start high, required 1",
                     bus.stall_req);
        end
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_rst_abort();
        test_ignored_start();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
# ex_mdu

Iterative multiply/divide unit and its sequencing controller, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation (unsigned subset) at a time and runs a fixed 32-iteration shift-add or restoring-divide loop. While it runs it holds the pipeline with a stall request, then presents the result on the same `rd_addr` / `rd_data` / `rd_wen` triple the ALU drives toward the register file.

## Interface
- `XLEN`, default 32: operand and result width. Iteration count equals `XLEN`.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `op` input 2: operation select. 0 = MUL (low word), 1 = MULHU (high word), 2 = DIVU, 3 = REMU.
- `op1` input XLEN: rs1 value (multiplicand / dividend).
- `op2` input XLEN: rs2 value (multiplier / divisor).
- `rd_addr_in` input 5: destination register of the operation.
- `flush` input 1: abort any in-flight operation (branch/jump kill).
- `busy` output 1: high in CALC and DONE.
- `stall_req` output 1: pipeline hold request to the stage registers.
- `valid` output 1: single-cycle result strobe.
- `rd_addr` output 5: destination register, qualified by `rd_wen`.
- `rd_data` output XLEN: result, qualified by `rd_wen`.
- `rd_wen` output 1: register-file write enable. Identical to `valid`.

## Operation
- FSM states: IDLE, CALC, DONE. The state is registered.
- **IDLE**
  - `start`=1 and `flush`=0: latch `op`, `op1`, `op2`, `rd_addr_in`; clear the iteration counter, accumulator and remainder.
  - Then go to CALC, except DIVU/REMU with `op2`=0, which go directly to DONE.
- **CALC**
  - One iteration per cycle. The 6-bit counter runs 0..XLEN-1.
  - After the iteration with counter = XLEN-1, go to DONE.
  - Iteration count is fixed and does not depend on the data.
- **DONE**
  - Drive `valid`=`rd_wen`=1, `rd_addr`=latched address, `rd_data`=result for exactly one cycle.
  - Then go to IDLE.
- Results are modulo 2^XLEN. The multiply is a full 2·XLEN-bit unsigned product: MUL returns bits [XLEN-1:0], MULHU returns bits [2·XLEN-1:XLEN].
- DIVU returns floor(op1/op2) and REMU returns op1 mod op2, both unsigned.
- Divide by zero: DIVU returns all-ones and REMU returns op1, per RISC-V. No trap.
- `stall_req` = (IDLE & `start` & ~`flush`) | CALC. It is combinational, so the issuing instruction is held in the same cycle it is presented. It is low in DONE so the pipeline advances while the result writes back.
- Outside DONE: `rd_data`=0, `rd_addr`=0, `rd_wen`=0.
- `start` while not IDLE is ignored. There is no queuing and the operands are not re-latched.
- `flush` in CALC or DONE forces IDLE on the next edge. It suppresses `valid`/`rd_wen` combinationally in that same cycle. `flush` with `start` in IDLE means the start is not accepted.
- Simultaneous `rst` and `flush`: `rst` wins. The outcome is identical either way.

## Timing
- Reset, asserted at any edge including mid-CALC:
  - Next cycle: state IDLE, counter 0, latched operands 0.
  - Outputs: `busy`=0, `stall_req`=0, `valid`=0, `rd_wen`=0, `rd_addr`=0, `rd_data`=0.
  - The in-flight result is discarded.
- Normal op with `start` accepted at edge k:
  - CALC during cycles k+1..k+XLEN.
  - DONE in cycle k+XLEN+1 (k+33 for XLEN=32).
  - IDLE from k+XLEN+2.
- Divide by zero accepted at edge k: DONE in cycle k+1, IDLE at k+2.
- `stall_req` is high from the accept cycle through the last CALC cycle: XLEN+1 cycles for a normal op, 1 cycle for divide by zero.
- Back-to-back: a new `start` is first accepted in the cycle after DONE. Minimum issue interval is XLEN+2 cycles.

## Test plan
- MUL: `op1`=7, `op2`=6, `rd_addr_in`=5, start at k.
  - Cycle k+33: `valid`=`rd_wen`=1, `rd_data`=42, `rd_addr`=5.
  - `stall_req` high for cycles k..k+32 and low at k+33.
- MULHU: `op1`=`op2`=0xFFFFFFFF gives `rd_data`=0xFFFFFFFE.
- MUL with the same operands gives `rd_data`=0x00000001.
- DIVU and REMU with `op1`=100, `op2`=7: DIVU gives 14 and REMU gives 2, each at k+33.
- Same ops with `op1`=0x80000000, `op2`=1: DIVU gives 0x80000000, REMU gives 0.
- Divide by zero, `op1`=0x1234, `op2`=0: DIVU gives 0xFFFFFFFF at k+1 and REMU gives 0x1234 at k+1. `stall_req` is high only in cycle k.
- Abort and ignored start:
  - Pulse `flush` at k+10 of a DIVU: no `valid` ever, IDLE at k+11.
  - Repeat with `rst` at k+10: all outputs 0 at k+11.
  - Pulse `start` at k+5 with different operands: the original result still returns at k+33, and the second request is not executed.
